// File: rtl/cache_ctrl_2way.sv
// rtl/cache_ctrl_2way.sv - write-back, write-allocate LRU controller for a 2-way, 2-set cache
module cache_ctrl_2way #(
   parameter int WORD_W = 16,
   parameter int LINE_W = 64,
   parameter int TAG_W  = 13,
   parameter int ENT_W  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [TAG_W+2:0]  cpu_addr,
   input  logic [WORD_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [WORD_W-1:0] cpu_rdata,
   output logic              arr_index,
   output logic              arr_we,
   input  logic [ENT_W-1:0]  tag_read_way1,
   input  logic [ENT_W-1:0]  tag_read_way2,
   input  logic [LINE_W-1:0] data_read_way1,
   input  logic [LINE_W-1:0] data_read_way2,
   output logic [ENT_W-1:0]  tag_write_way1,
   output logic [ENT_W-1:0]  tag_write_way2,
   output logic [LINE_W-1:0] data_write_way1,
   output logic [LINE_W-1:0] data_write_way2,
   output logic              mem_req,
   output logic              mem_we,
   output logic [TAG_W:0]    mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_COMPARE   = 2'd1;
   localparam logic [1:0] S_WRITEBACK = 2'd2;
   localparam logic [1:0] S_ALLOCATE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [TAG_W+2:0]  addr_q, addr_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [1:0]        lru_q, lru_d;
   logic              victim_q, victim_d;
   logic              retry_q, retry_d;
   logic [15:0]       hit_q, hit_d, miss_q, miss_d;

   logic              req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [1:0]        req_word;
   logic              hit1, hit2;
   logic [LINE_W-1:0] hit_line, merged;
   logic              vic_sel, vic_dirty;
   logic [TAG_W-1:0]  vic_tag;
   logic [LINE_W-1:0] vic_line;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign req_idx  = addr_q[2];
   assign req_tag  = addr_q[TAG_W+2:3];
   assign req_word = addr_q[1:0];
   assign hit1     = tag_read_way1[ENT_W-1] && (tag_read_way1[TAG_W-1:0] == req_tag);
   assign hit2     = tag_read_way2[ENT_W-1] && (tag_read_way2[TAG_W-1:0] == req_tag);
   assign hit_line = hit1 ? data_read_way1 : data_read_way2;

   // Invalid ways are filled first; only a full set consults the LRU bit.
   assign vic_sel   = !tag_read_way1[ENT_W-1] ? 1'b0 :
                      (!tag_read_way2[ENT_W-1] ? 1'b1 : lru_q[req_idx]);
   assign vic_dirty = vic_sel ? (tag_read_way2[ENT_W-1] & tag_read_way2[ENT_W-2])
                              : (tag_read_way1[ENT_W-1] & tag_read_way1[ENT_W-2]);
   assign vic_tag   = victim_q ? tag_read_way2[TAG_W-1:0] : tag_read_way1[TAG_W-1:0];
   assign vic_line  = victim_q ? data_read_way2 : data_read_way1;

   assign hit_count  = hit_q;
   assign miss_count = miss_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         lru_q    <= '0;
         victim_q <= 1'b0;
         retry_q  <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         lru_q    <= lru_d;
         victim_q <= victim_d;
         retry_q  <= retry_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      lru_d    = lru_q;
      victim_d = victim_q;
      retry_d  = retry_q;
      hit_d    = hit_q;
      miss_d   = miss_q;

      cpu_ready       = 1'b0;
      cpu_rdata       = '0;
      arr_index       = (state_q == S_IDLE) ? cpu_addr[2] : req_idx;
      arr_we          = 1'b0;
      tag_write_way1  = tag_read_way1;
      tag_write_way2  = tag_read_way2;
      data_write_way1 = data_read_way1;
      data_write_way2 = data_read_way2;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;

      merged = hit_line;
      merged[int'(req_word)*WORD_W +: WORD_W] = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               retry_d = 1'b0;
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit1 || hit2) begin
               cpu_ready = 1'b1;
               cpu_rdata = hit_line[int'(req_word)*WORD_W +: WORD_W];
               if (we_q) begin
                  arr_we = 1'b1;
                  if (hit1) begin
                     tag_write_way1  = {2'b11, req_tag};
                     data_write_way1 = merged;
                  end else begin
                     tag_write_way2  = {2'b11, req_tag};
                     data_write_way2 = merged;
                  end
               end
               lru_d[req_idx] = hit1;
               if (!retry_q) hit_d = sat_inc(hit_q);
               retry_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               // The post-refill pass must not count twice.
               if (!retry_q) miss_d = sat_inc(miss_q);
               victim_d = vic_sel;
               state_d  = vic_dirty ? S_WRITEBACK : S_ALLOCATE;
            end
         end
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vic_tag, req_idx};
            mem_wdata = vic_line;
            if (mem_ack) state_d = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = addr_q[TAG_W+2:2];
            if (mem_ack) begin
               arr_we = 1'b1;
               if (victim_q) begin
                  tag_write_way2  = {2'b10, req_tag};
                  data_write_way2 = mem_rdata;
               end else begin
                  tag_write_way1  = {2'b10, req_tag};
                  data_write_way1 = mem_rdata;
               end
               retry_d = 1'b1;
               state_d = S_COMPARE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb/tb_cache_ctrl_2way.sv - randomized self-checking bench for cache_ctrl_2way
module tb_cache_ctrl_2way;

   typedef struct packed {
      logic        we;
      logic [13:0] addr;
      logic [63:0] data;
   } mtx_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        cpu_ready;
   logic [15:0] cpu_rdata;
   logic        arr_index, arr_we;
   logic [14:0] tag_read_way1, tag_read_way2, tag_write_way1, tag_write_way2;
   logic [63:0] data_read_way1, data_read_way2, data_write_way1, data_write_way2;
   logic        mem_req, mem_we, mem_ack;
   logic [13:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic [15:0] hit_count, miss_count;

   int n_assert = 0;
   int n_fail   = 0;

   cache_ctrl_2way dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .arr_index(arr_index), .arr_we(arr_we),
      .tag_read_way1(tag_read_way1), .tag_read_way2(tag_read_way2),
      .data_read_way1(data_read_way1), .data_read_way2(data_read_way2),
      .tag_write_way1(tag_write_way1), .tag_write_way2(tag_write_way2),
      .data_write_way1(data_write_way1), .data_write_way2(data_write_way2),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Tag/data arrays, slot = {set, way}, way 0 = way1
   logic [14:0] tag_arr  [4] = '{default: '0};
   logic [63:0] data_arr [4] = '{default: '0};
   int          we_pulses = 0;
   logic [14:0] last_tw1, last_tw2;
   logic [63:0] last_dw1, last_dw2;

   assign tag_read_way1  = tag_arr[{arr_index, 1'b0}];
   assign tag_read_way2  = tag_arr[{arr_index, 1'b1}];
   assign data_read_way1 = data_arr[{arr_index, 1'b0}];
   assign data_read_way2 = data_arr[{arr_index, 1'b1}];

   always @(posedge clk) begin
      if (arr_we) begin
         tag_arr[{arr_index, 1'b0}]  <= tag_write_way1;
         tag_arr[{arr_index, 1'b1}]  <= tag_write_way2;
         data_arr[{arr_index, 1'b0}] <= data_write_way1;
         data_arr[{arr_index, 1'b1}] <= data_write_way2;
         last_tw1  <= tag_write_way1;
         last_tw2  <= tag_write_way2;
         last_dw1  <= data_write_way1;
         last_dw2  <= data_write_way2;
         we_pulses <= we_pulses + 1;
      end
   end

   function automatic logic [63:0] init_line(input int a);
      logic [15:0] b;
      b = 16'(a * 4);
      return {b ^ 16'hC003, b ^ 16'hB002, b ^ 16'hA001, b ^ 16'h9000};
   endfunction

   // Main memory with configurable ack latency; logs every completed transfer
   logic [63:0] mem [int];
   logic        ack_hold  = 1'b0;
   int          ack_delay = 0;
   int          rsp_wait;
   mtx_t        rsp_t;
   mtx_t        mon_q [$];

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      rsp_wait  = 0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req && !reset) begin
            if (ack_hold || rsp_wait < ack_delay) begin
               rsp_wait++;
            end else begin
               rsp_wait   = 0;
               rsp_t.we   = mem_we;
               rsp_t.addr = mem_addr;
               rsp_t.data = mem_wdata;
               if (mem_we) begin
                  mem[int'(mem_addr)] = mem_wdata;
               end else begin
                  mem_rdata  = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : init_line(int'(mem_addr));
                  rsp_t.data = mem_rdata;
               end
               mon_q.push_back(rsp_t);
               mem_ack = 1'b1;
            end
         end else begin
            rsp_wait = 0;
         end
      end
   end

   // Reference cache: per-slot valid/dirty/tag/line, per-set LRU, own memory image
   logic        m_v [4];
   logic        m_d [4];
   logic [12:0] m_tag [4];
   logic [63:0] m_line [4];
   logic        m_lru [2];
   int          m_hits, m_miss;
   logic [63:0] ref_mem [int];
   mtx_t        exp_q [$];
   logic        exp_hit;
   logic [15:0] exp_rdata;
   int          exp_cycles;

   function automatic logic [63:0] ref_line(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
   endfunction

   task automatic model_reset();
      m_lru[0] = 1'b0;
      m_lru[1] = 1'b0;
      m_hits   = 0;
      m_miss   = 0;
   endtask

   task automatic model_access(input logic [15:0] a, input logic we, input logic [15:0] wd, input logic b2b);
      int s, w, way, slot;
      logic [12:0] tg;
      mtx_t t;
      s = int'(a[2]);
      w = int'(a[1:0]);
      tg = a[15:3];
      exp_q.delete();
      way = -1;
      for (int i = 0; i < 2; i++)
         if (m_v[s*2+i] && m_tag[s*2+i] == tg) way = i;
      exp_hit = (way >= 0);
      if (exp_hit) begin
         if (m_hits < 65535) m_hits++;
         exp_cycles = 1;
      end else begin
         if (m_miss < 65535) m_miss++;
         if (!m_v[s*2]) way = 0;
         else if (!m_v[s*2+1]) way = 1;
         else way = int'(m_lru[s]);
         slot = s*2 + way;
         exp_cycles = 3 + ack_delay;
         if (m_v[slot] && m_d[slot]) begin
            t.we   = 1'b1;
            t.addr = 14'(int'(m_tag[slot]) * 2 + s);
            t.data = m_line[slot];
            ref_mem[int'(t.addr)] = t.data;
            exp_q.push_back(t);
            exp_cycles = 4 + 2 * ack_delay;
         end
         t.we   = 1'b0;
         t.addr = a[15:2];
         t.data = ref_line(int'(a[15:2]));
         exp_q.push_back(t);
         m_v[slot]    = 1'b1;
         m_d[slot]    = 1'b0;
         m_tag[slot]  = tg;
         m_line[slot] = t.data;
      end
      if (b2b) exp_cycles++;
      slot = s*2 + way;
      exp_rdata = m_line[slot][w*16 +: 16];
      if (we) begin
         m_line[slot][w*16 +: 16] = wd;
         m_d[slot] = 1'b1;
      end
      m_lru[s] = (way == 0);
   endtask

   task automatic do_access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                            input logic b2b, input string nm, output logic [15:0] rd);
      int cycles;
      logic got;
      model_access(a, we, wd, b2b);
      mon_q.delete();
      if (!b2b) @(negedge clk);
      cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
      cycles = 0; got = 1'b0;
      while (!got && cycles < 200) begin
         @(negedge clk);
         cycles++;
         got = cpu_ready;
      end
      rd = cpu_rdata;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      n_assert++;
      if (!got) begin n_fail++; $display("FAIL %s ready: no cpu_ready within %0d cycles", nm, cycles); end
      n_assert++;
      if (cycles != exp_cycles) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", nm, cycles, exp_cycles); end
      if (!we) begin
         n_assert++;
         if (rd !== exp_rdata) begin n_fail++; $display("FAIL %s rdata: got %h required %h", nm, rd, exp_rdata); end
      end
      n_assert++;
      if (mon_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL %s mem_count: got %0d required %0d", nm, mon_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            n_assert++;
            if (mon_q[i].we !== exp_q[i].we || mon_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && mon_q[i].data !== exp_q[i].data)) begin
               n_fail++;
               $display("FAIL %s mem_tx%0d: got we=%b addr=%h data=%h required we=%b addr=%h data=%h", nm, i,
                        mon_q[i].we, mon_q[i].addr, mon_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
         end
      end
      n_assert++;
      if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_miss)) begin
         n_fail++; $display("FAIL %s counters: got hit=%0d miss=%0d required hit=%0d miss=%0d", nm, hit_count, miss_count, m_hits, m_miss);
      end
      n_assert++;
      if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_pulse: got %b required 0", nm, cpu_ready); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_assert++;
      if (cpu_ready !== 1'b0 || mem_req !== 1'b0 || arr_we !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs: got ready=%b mem_req=%b arr_we=%b required 0", cpu_ready, mem_req, arr_we);
      end
      n_assert++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_counters: got hit=%0d miss=%0d required 0", hit_count, miss_count);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_assert++;
      if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: got mem_req=%b ready=%b required 0", mem_req, cpu_ready);
      end
   endtask

   task automatic test_plan();
      logic [15:0] rd;
      logic [14:0] t2;
      logic [63:0] d2;
      int p0;
      mem[4]     = 64'h4444_3333_2222_1111;
      ref_mem[4] = 64'h4444_3333_2222_1111;
      ack_delay  = 1;
      do_access(16'h0010, 1'b0, 16'h0, 1'b0, "rd_0010", rd);
      n_assert++;
      if (rd !== 16'h1111) begin n_fail++; $display("FAIL plan_rd_0010: got %h required 1111", rd); end
      n_assert++;
      if (tag_arr[0] !== 15'h4002) begin n_fail++; $display("FAIL plan_way1_entry: got %h required 4002", tag_arr[0]); end
      do_access(16'h0012, 1'b0, 16'h0, 1'b0, "rd_0012", rd);
      n_assert++;
      if (rd !== 16'h3333 || hit_count !== 16'd1) begin
         n_fail++; $display("FAIL plan_rd_0012: got %h hit=%0d required 3333 hit=1", rd, hit_count);
      end
      t2 = tag_arr[1]; d2 = data_arr[1]; p0 = we_pulses;
      do_access(16'h0011, 1'b1, 16'hBEEF, 1'b0, "wr_0011", rd);
      n_assert++;
      if (we_pulses - p0 != 1) begin n_fail++; $display("FAIL plan_wr_pulses: got %0d required 1", we_pulses - p0); end
      n_assert++;
      if (last_tw1 !== 15'h6002 || last_dw1[31:16] !== 16'hBEEF) begin
         n_fail++; $display("FAIL plan_wr_way1: got tag=%h word1=%h required tag=6002 word1=beef", last_tw1, last_dw1[31:16]);
      end
      n_assert++;
      if (last_tw2 !== t2 || last_dw2 !== d2) begin
         n_fail++; $display("FAIL plan_wr_way2_kept: got %h/%h required %h/%h", last_tw2, last_dw2, t2, d2);
      end
      do_access(16'h0030, 1'b0, 16'h0, 1'b0, "rd_0030", rd);
      n_assert++;
      if (tag_arr[1] !== 15'h4006) begin n_fail++; $display("FAIL plan_way2_fill: got %h required 4006", tag_arr[1]); end
      do_access(16'h0050, 1'b0, 16'h0, 1'b0, "rd_0050", rd);
      n_assert++;
      if (mon_q.size() != 2) begin
         n_fail++; $display("FAIL plan_evict_count: got %0d required 2", mon_q.size());
      end else if (mon_q[0].we !== 1'b1 || mon_q[0].addr !== 14'h0004 || mon_q[0].data[31:16] !== 16'hBEEF ||
                   mon_q[1].we !== 1'b0 || mon_q[1].addr !== 14'h0014) begin
         n_fail++; $display("FAIL plan_evict: got wb=%b/%h/%h alloc=%b/%h required 1/0004/beef 0/0014",
                            mon_q[0].we, mon_q[0].addr, mon_q[0].data[31:16], mon_q[1].we, mon_q[1].addr);
      end
   endtask

   task automatic test_reset_mid_allocate();
      int cycles;
      ack_hold = 1'b1;
      @(negedge clk);
      cpu_addr = 16'h1FFC; cpu_we = 1'b0; cpu_req = 1'b1;
      cycles = 0;
      while (!mem_req && cycles < 20) begin @(negedge clk); cycles++; end
      n_assert++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_alloc_reach: got mem_req=%b mem_we=%b required 1/0", mem_req, mem_we); end
      #2;
      reset = 1'b1; cpu_req = 1'b0;
      #1;
      n_assert++;
      if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alloc_immediate: got mem_req=%b ready=%b required 0", mem_req, cpu_ready); end
      n_assert++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_fail++; $display("FAIL rst_alloc_counters: got %0d/%0d required 0/0", hit_count, miss_count); end
      @(negedge clk);
      reset = 1'b0; ack_hold = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_assert++;
         if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_alloc_idle: got ready=%b mem_req=%b required 0", cpu_ready, mem_req); end
      end
   endtask

   task automatic test_ack_stall();
      int cycles;
      logic got;
      logic [13:0] a0;
      logic [15:0] rd;
      ack_delay = 0;
      model_access(16'h0004, 1'b0, 16'h0, 1'b0);
      mon_q.delete();
      ack_hold = 1'b1;
      @(negedge clk);
      cpu_addr = 16'h0004; cpu_we = 1'b0; cpu_req = 1'b1;
      cycles = 0;
      while (!mem_req && cycles < 20) begin @(negedge clk); cycles++; end
      a0 = mem_addr;
      n_assert++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || a0 !== 14'h0001) begin
         n_fail++; $display("FAIL stall_req: got req=%b we=%b addr=%h required 1/0/0001", mem_req, mem_we, a0);
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_assert++;
         if (mem_req !== 1'b1 || mem_addr !== a0 || cpu_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold%0d: got req=%b addr=%h ready=%b required 1/%h/0", i, mem_req, mem_addr, cpu_ready, a0);
         end
      end
      ack_hold = 1'b0;
      cycles = 0; got = 1'b0;
      while (!got && cycles < 20) begin @(negedge clk); cycles++; got = cpu_ready; end
      rd = cpu_rdata;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      n_assert++;
      if (!got || rd !== exp_rdata) begin n_fail++; $display("FAIL stall_done: got ready=%b rdata=%h required 1/%h", got, rd, exp_rdata); end
      n_assert++;
      if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_miss)) begin
         n_fail++; $display("FAIL stall_counters: got %0d/%0d required %0d/%0d", hit_count, miss_count, m_hits, m_miss);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] rd;
      ack_delay = 0;
      do_access(16'h0031, 1'b0, 16'h0,    1'b0, "b2b_0", rd);
      do_access(16'h0032, 1'b0, 16'h0,    1'b1, "b2b_1", rd);
      do_access(16'h0053, 1'b1, 16'h1234, 1'b1, "b2b_2", rd);
      do_access(16'h0053, 1'b0, 16'h0,    1'b1, "b2b_3", rd);
      do_access(16'h0005, 1'b0, 16'h0,    1'b1, "b2b_4", rd);
   endtask

   task automatic test_random();
      logic [15:0] a, wd, rd;
      logic we, b2b;
      for (int n = 0; n < 150; n++) begin
         a  = {13'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
         we = 1'($urandom_range(0, 1));
         wd = 16'($urandom);
         b2b = 1'($urandom_range(0, 1));
         ack_delay = $urandom_range(0, 3);
         do_access(a, we, wd, b2b, "random", rd);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_v[i] = 1'b0; m_d[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
      end
      model_reset();
      test_reset();
      test_plan();
      test_reset_mid_allocate();
      test_ack_stall();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Controller FSM for the 2-way set-associative, 2-set, 4-line cache.
- Sits between the CPU memory port and the cache tag/data arrays, and owns the refill/writeback path to main memory.
- Write-back, write-allocate policy; LRU replacement per set.
- Drives the array request index and write-enable, supplies both ways' write data, and counts hits and misses.

Parameters:
- WORD_W, 16, CPU word width
- LINE_W, 64, cache line width (4 words)
- TAG_W, 13, address tag width
- ENT_W, 15, tag-array entry width: {valid, dirty, tag}

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  request valid; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  word address: [15:3] tag, [2] index, [1:0] word offset
- cpu_wdata  in  16  store data
- cpu_ready  out  1  one-cycle pulse: request complete
- cpu_rdata  out  16  load data, valid while cpu_ready=1
- arr_index  out  1  set index presented to both arrays
- arr_we  out  1  array write enable; writes both ways at arr_index
- tag_read_way1, tag_read_way2  in  15  combinational tag entries at arr_index
- data_read_way1, data_read_way2  in  64  combinational lines at arr_index
- tag_write_way1, tag_write_way2  out  15  tag write data
- data_write_way1, data_write_way2  out  64  line write data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = line writeback
- mem_addr  out  14  line address {tag, index}
- mem_wdata  out  64  writeback line
- mem_rdata  in  64  refill line, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- hit_count, miss_count  out  16  saturating event counters

Behaviour:
- Entry format: bit14 valid, bit13 dirty, bits12:0 tag.
- Way hit: valid=1 and tag == cpu_addr[15:3].
- Word w of a line occupies bits [16w+15:16w].
- Reset: asynchronous, effective immediately, regardless of FSM state.
  - State goes to IDLE; both LRU bits, counters and all outputs go to 0.
  - An in-flight memory request is abandoned.
- States:
  - IDLE: arr_index follows cpu_addr[2]. If cpu_req=1, latch addr/we/wdata and go to COMPARE.
  - COMPARE (hit): cpu_ready=1 for one cycle, hit_count+1.
    - Read: cpu_rdata = selected word of the hit way.
    - Write: arr_we=1; hit way gets the word merged and dirty=1.
    - LRU[index] = other way. Next state IDLE.
  - COMPARE (miss, first pass): miss_count+1 and select the victim.
    - Victim: invalid way1, else invalid way2, else the way named by LRU[index] (0 = way1).
    - Victim dirty goes to WRITEBACK; otherwise to ALLOCATE.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim line. On mem_ack go to ALLOCATE.
  - ALLOCATE: mem_req=1, mem_we=0, mem_addr=latched addr[15:2].
    - On mem_ack: arr_we=1; victim entry = {1, 0, req tag}, victim data = mem_rdata.
    - Next state COMPARE, which re-evaluates as a hit; this retry is not counted as a miss or a hit.
- Non-written way: whenever arr_we=1, the way not being written is driven with its current tag_read/data_read value, so it is preserved.
- Array outputs: arr_we=0 in all other cycles. tag_write/data_write default to the read values.
- Latency (cpu_req sampled in IDLE to cpu_ready):
  - Hit: cpu_ready in the cycle after the request is sampled.
  - Clean miss: cycle after mem_ack + 1.
  - Dirty miss: adds the writeback handshake.
- cpu_req changes while busy are ignored; the latched request is used.
- Counters saturate at 16'hFFFF.
- mem_req deasserts in the cycle after mem_ack. A mem_ack while mem_req=0 is ignored.
- After cpu_ready, the next request is accepted no earlier than the following IDLE cycle; back-to-back requests cost one IDLE cycle each.

Test Plan:
- Reset, then read 0x0010 with memory returning line 0x4444_3333_2222_1111.
  - Required: one ALLOCATE on line addr 0x0004; cpu_rdata=0x1111.
  - miss_count=1, hit_count=0; way1 entry = {1, 0, 13'h0002}.
- Read 0x0012 next.
  - Required: hit with no memory traffic, cpu_ready 1 cycle after sampling, cpu_rdata=0x3333, hit_count=1.
- Write 0xBEEF to 0x0011.
  - Required: hit, arr_we pulse with word1 = 0xBEEF and dirty=1; way2 entry and data rewritten unchanged.
- Read 0x0030 (same set 0, new tag), then 0x0050.
  - 0x0030 fills way2.
  - 0x0050 evicts way1 (LRU after the 0x0030 access) via WRITEBACK: mem_addr=0x0004, line containing 0xBEEF, then ALLOCATE on 0x0014.
- Assert reset for 1 cycle mid-ALLOCATE.
  - Required: mem_req=0 immediately, state IDLE, counters 0, no cpu_ready.
- Hold mem_ack low for 50 cycles in ALLOCATE.
  - Required: mem_req stays 1 with a stable mem_addr; cpu_ready stays 0.
